// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and types for the reg_file_sb register file
//
// Purpose: default geometry of the RV32IM integer register file and the
//          word/address types used by the register file and its scoreboard.
// Ports:   none (package).
package reg_file_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int REGFILE_DEF = 32;

  typedef logic [XLEN_DEF-1:0]   word_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits with claim, writeback release and flush
//
// Purpose: tracks which architectural registers have a write in flight.
//          A claim sets a busy bit, a write releases it, flush clears all.
// Ports:
//   clk, n_reset          clock, asynchronous active-low reset
//   rd_addr  [NRD*ADDR_W] lookup addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_busy  [NRD]        busy bit of each looked-up register (x0 always 0)
//   we       [NWR]        write enables of the writeback ports
//   wr_addr  [NWR*ADDR_W] writeback addresses
//   claim_valid/addr      issue-stage claim request
//   claim_ok              claim accepted this cycle (combinational)
//   flush                 clear every busy bit at the next edge
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int REGFILE = REGFILE_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 1
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic                  claim_valid,
  input  logic [ADDR_W-1:0]     claim_addr,
  output logic                  claim_ok,
  input  logic                  flush
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(REGFILE);

  logic [REGFILE-1:0] busy;

  // Non-zero and inside the implemented register range.
  function automatic logic valid_reg(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < LIMIT);
  endfunction

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (valid_reg(rd_addr[i*ADDR_W +: ADDR_W]))
        rd_busy[i] = busy[rd_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  assign claim_ok = claim_valid && valid_reg(claim_addr) && !busy[claim_addr] && !flush;

  // Clears are applied first so a claim to the register being written back
  // in the same cycle leaves it busy. Flush takes priority over everything;
  // claim_ok is already low during flush.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && valid_reg(wr_addr[j*ADDR_W +: ADDR_W]))
          busy[wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (claim_ok)
        busy[claim_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port integer register file with integrated scoreboard
//
// Purpose: RV32IM register file, x0 hardwired to zero, combinational reads
//          returning data plus pending-write status for hazard detection.
// Config:  define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding;
//          without it reads are read-before-write.
// Ports:
//   clk, n_reset          clock, asynchronous active-low reset
//   rs_addr  [NRD*ADDR_W] read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rs_data  [NRD*XLEN]   read data, port i at [i*XLEN +: XLEN]
//   rs_busy  [NRD]        addressed register has a pending write
//   we       [NWR]        write enables (higher index wins on conflict)
//   wr_addr  [NWR*ADDR_W] write addresses
//   wr_data  [NWR*XLEN]   write data
//   claim_valid/addr      issue stage claims a destination register
//   claim_ok              claim accepted this cycle (combinational)
//   flush                 clear all busy bits at the next edge
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int REGFILE = REGFILE_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 1
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [NRD*ADDR_W-1:0] rs_addr,
  output logic [NRD*XLEN-1:0]   rs_data,
  output logic [NRD-1:0]        rs_busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic                  claim_valid,
  input  logic [ADDR_W-1:0]     claim_addr,
  output logic                  claim_ok,
  input  logic                  flush
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(REGFILE);

  logic [XLEN-1:0] regs [REGFILE];
  logic [NRD-1:0]  sb_busy;

  function automatic logic valid_reg(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < LIMIT);
  endfunction

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .REGFILE (REGFILE),
    .NRD     (NRD),
    .NWR     (NWR)
  ) u_scoreboard (
    .clk         (clk),
    .n_reset     (n_reset),
    .rd_addr     (rs_addr),
    .rd_busy     (sb_busy),
    .we          (we),
    .wr_addr     (wr_addr),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ok    (claim_ok),
    .flush       (flush)
  );

  // Ports are walked in ascending order so the highest-indexed writer wins.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int k = 0; k < REGFILE; k++)
        regs[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && valid_reg(wr_addr[j*ADDR_W +: ADDR_W]))
          regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rs_addr[i*ADDR_W +: ADDR_W];
      if (valid_reg(a))
        rs_data[i*XLEN +: XLEN] = regs[a];
      rs_busy[i] = sb_busy[i];
`ifdef REGFILE_BYPASS_EN
      // A matching write forwards its data and hides the busy bit it is
      // about to release, unless a claim re-owns the register this cycle.
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && valid_reg(a) && (wr_addr[j*ADDR_W +: ADDR_W] == a)) begin
          rs_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          rs_busy[i]              = claim_ok && (claim_addr == a);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb
module tb_reg_file_sb;
  import reg_file_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_reset;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic [1:0]  we;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic        claim_ok;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.ADDR_W(5), .XLEN(32), .REGFILE(32), .NRD(2), .NWR(2)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .rs_addr     (rs_addr),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .claim_ok    (claim_ok),
    .flush       (flush)
  );

  typedef struct {
    logic [4:0] a0, a1;
    logic [1:0] we;
    logic [4:0] wa0, wa1;
    word_t      wd0, wd1;
    logic       cv;
    logic [4:0] ca;
    logic       fl;
    word_t      e0, e1;
    logic [1:0] eb;
    logic       eok;
  } vec_t;

  typedef struct {
    int         idx;
    word_t      e0, e1;
    logic [1:0] eb;
    logic       eok;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  function automatic vec_t mk(input logic [4:0] a0, a1, input logic [1:0] w,
                              input logic [4:0] wa0, input word_t wd0,
                              input logic [4:0] wa1, input word_t wd1,
                              input logic cv, input logic [4:0] ca, input logic fl,
                              input word_t e0, e1, input logic [1:0] eb, input logic eok);
    vec_t v;
    v.a0 = a0; v.a1 = a1; v.we = w; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.cv = cv; v.ca = ca; v.fl = fl; v.e0 = e0; v.e1 = e1; v.eb = eb; v.eok = eok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = '0; wr_addr = '0; wr_data = '0;
    claim_valid = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    rs_addr     = {v.a1, v.a0};
    we          = v.we;
    wr_addr     = {v.wa1, v.wa0};
    wr_data     = {v.wd1, v.wd0};
    claim_valid = v.cv;
    claim_addr  = v.ca;
    flush       = v.fl;
  endtask

  initial begin
    exp_t e;
    n_reset = 1'b0;
    rs_addr = {5'd31, 5'd5};
    idle();

    // Reset state, observed while reset is held.
    repeat (2) @(negedge clk);
    chk("reset_data0", rs_data[31:0], 32'h0);
    chk("reset_data1", rs_data[63:32], 32'h0);
    chk("reset_busy", {30'd0, rs_busy}, 32'h0);
    n_reset = 1'b1;

    // a0 a1 we wa0 wd0 wa1 wd1 cv ca fl | e0 e1 busy{p1,p0} ok
    vecs.push_back(mk(5, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(31, 5, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(7, 7, 1, 7, 32'h1234_5678, 0, 0, 0, 0, 0,
                      BYP ? 32'h1234_5678 : 32'h0, BYP ? 32'h1234_5678 : 32'h0, 2'b00, 0));
    vecs.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 2'b00, 0));
    vecs.push_back(mk(3, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 2'b00, 1));
    vecs.push_back(mk(3, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 2'b11, 0));
    vecs.push_back(mk(3, 3, 1, 3, 32'hA5, 0, 0, 0, 0, 0,
                      BYP ? 32'hA5 : 32'h0, BYP ? 32'hA5 : 32'h0, BYP ? 2'b00 : 2'b11, 0));
    vecs.push_back(mk(3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA5, 32'h1234_5678, 2'b00, 0));
    vecs.push_back(mk(9, 3, 1, 9, 32'h55, 0, 0, 1, 9, 0,
                      BYP ? 32'h55 : 32'h0, 32'hA5, BYP ? 2'b01 : 2'b00, 1));
    vecs.push_back(mk(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55, 32'h55, 2'b11, 0));
    vecs.push_back(mk(4, 9, 2'b11, 4, 32'h11, 4, 32'h22, 0, 0, 0,
                      BYP ? 32'h22 : 32'h0, 32'h55, 2'b10, 0));
    vecs.push_back(mk(4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22, 32'h22, 2'b00, 0));
    vecs.push_back(mk(10, 9, 0, 0, 0, 0, 0, 1, 10, 0, 0, 32'h55, 2'b10, 1));
    vecs.push_back(mk(10, 11, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 2'b01, 1));
    vecs.push_back(mk(11, 12, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 2'b01, 1));
    vecs.push_back(mk(10, 13, 0, 0, 0, 0, 0, 1, 13, 1, 0, 0, 2'b01, 0));
    vecs.push_back(mk(10, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(9, 13, 0, 0, 0, 0, 0, 1, 0, 0, 32'h55, 0, 2'b00, 0));
    vecs.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      drive(vecs[k]);
      e.idx = k; e.e0 = vecs[k].e0; e.e1 = vecs[k].e1; e.eb = vecs[k].eb; e.eok = vecs[k].eok;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_data0", e.idx), rs_data[31:0], e.e0);
        chk($sformatf("v%0d_data1", e.idx), rs_data[63:32], e.e1);
        chk($sformatf("v%0d_busy", e.idx), {30'd0, rs_busy}, {30'd0, e.eb});
        chk($sformatf("v%0d_claim_ok", e.idx), {31'd0, claim_ok}, {31'd0, e.eok});
      end
    end

    // Claim + write x6 together, then an asynchronous reset mid-cycle.
    @(posedge clk);
    #1;
    idle();
    rs_addr = {5'd6, 5'd6};
    we = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'hFF};
    claim_valid = 1'b1; claim_addr = 5'd6;
    @(negedge clk);
    chk("x6_claim_ok", {31'd0, claim_ok}, 32'd1);
    @(posedge clk);
    #1;
    idle();
    chk("x6_data_before_reset", rs_data[31:0], 32'hFF);
    chk("x6_busy_before_reset", {30'd0, rs_busy}, 32'd3);
    #1;
    n_reset = 1'b0;
    #1;
    chk("x6_data_async_reset", rs_data[31:0], 32'h0);
    chk("x6_busy_async_reset", {30'd0, rs_busy}, 32'd0);
    rs_addr = {5'd9, 5'd7};
    #1;
    chk("x7_after_reset", rs_data[31:0], 32'h0);
    chk("x9_after_reset", rs_data[63:32], 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    rs_addr = {5'd6, 5'd6};
    claim_valid = 1'b1; claim_addr = 5'd6;
    @(negedge clk);
    chk("x6_reclaim_ok", {31'd0, claim_ok}, 32'd1);
    chk("x6_busy_pre_reclaim", {30'd0, rs_busy}, 32'd0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("x6_busy_after_reclaim", {30'd0, rs_busy}, 32'd3);

    if (sb_q.size() != 0) chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
